// File: rtl/uart_pkg.sv
// Shared UART definitions: transmit-feeder FSM encoding and default buffer sizing.
package uart_pkg;

    localparam int unsigned UART_DEPTH  = 16;
    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_SEND       = 2'd1,
        ST_WAIT_START = 2'd2,
        ST_WAIT_DONE  = 2'd3
    } tx_state_e;

    // Occupancy counter width able to hold 0..depth inclusive.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Circular FIFO with registered pointers, occupancy count and full/empty flags.
module sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic             i_pop,
    input  logic [WIDTH-1:0] i_wr_data,
    output logic [WIDTH-1:0] o_head_c,
    output logic             o_full,
    output logic             o_empty,
    output logic [CNT_W-1:0] o_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_full;
    logic             r_empty;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_do_push;
    logic             w_do_pop;

    // A push into a full FIFO is still accepted when a pop frees a slot on the same edge.
    always_comb begin
        w_do_pop    = i_pop && !r_empty;
        w_do_push   = i_push && (!r_full || w_do_pop);
        w_count_nxt = r_count;
        if (w_do_push && !w_do_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (!w_do_push && w_do_pop) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    // Storage array; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_full   <= 1'b0;
            r_empty  <= 1'b1;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == CNT_W'(DEPTH));
            r_empty <= (w_count_nxt == '0);
        end
    end

    assign o_head_c = r_mem[r_rd_ptr];
    assign o_full   = r_full;
    assign o_empty  = r_empty;
    assign o_count  = r_count;

endmodule

// File: rtl/uart_tx_feeder.sv
// Buffers producer bytes and hands them one at a time to a UART transmitter.
module uart_tx_feeder
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = UART_DEPTH,
    parameter int unsigned CNT_W = cnt_width(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [7:0]       wr_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count,
    output logic             overflow,
    input  logic             tx_active,
    input  logic             tx_done,
    output logic             data_valid,
    output logic [7:0]       transmit_byte
);

    tx_state_e  r_state;
    tx_state_e  w_state_nxt;
    logic       r_tx_done_prev;
    logic       r_data_valid;
    logic       r_overflow;
    logic [7:0] r_transmit_byte;
    logic       w_pop;
    logic [7:0] w_head_c;
    logic       w_full;
    logic       w_empty;

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (UART_DATA_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (wr_en),
        .i_pop     (w_pop),
        .i_wr_data (wr_data),
        .o_head_c  (w_head_c),
        .o_full    (w_full),
        .o_empty   (w_empty),
        .o_count   (count)
    );

    // Next state; the pop happens on the IDLE->SEND edge, and a stale tx_done level blocks a start.
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_empty && !tx_active && !tx_done) begin
                    w_pop       = 1'b1;
                    w_state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                w_state_nxt = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (tx_active) begin
                    w_state_nxt = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                if (tx_done && !r_tx_done_prev) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // tx_done history, start strobe, captured byte and drop indication.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tx_done_prev  <= 1'b0;
            r_data_valid    <= 1'b0;
            r_overflow      <= 1'b0;
            r_transmit_byte <= 8'h00;
        end else begin
            r_tx_done_prev <= tx_done;
            r_data_valid   <= w_pop;
            r_overflow     <= wr_en && w_full && !w_pop;
            if (w_pop) begin
                r_transmit_byte <= w_head_c;
            end
        end
    end

    assign full          = w_full;
    assign empty         = w_empty;
    assign overflow      = r_overflow;
    assign data_valid    = r_data_valid;
    assign transmit_byte = r_transmit_byte;

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Randomized bench for uart_tx_feeder with a behavioural transmitter and byte scoreboard.
module tb_uart_tx_feeder;
    import uart_pkg::*;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned CNT_W = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_en;
    logic [7:0]       wr_data;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] count;
    logic             overflow;
    logic             tx_active;
    logic             tx_done;
    logic             data_valid;
    logic [7:0]       transmit_byte;

    int n_cmp = 0;
    int n_err = 0;
    int n_dv  = 0;
    int m_cnt = 0;
    bit m_ovf = 1'b0;
    logic [7:0] exp_q[$];
    logic [7:0] rx_q[$];

    // transmitter model knobs and state
    bit hold_busy = 1'b0;
    bit hold_done = 1'b0;
    int act_dly   = 0;
    int busy_len  = 1;
    int done_len  = 1;
    int xm_phase  = 0;
    int xm_cnt    = 0;
    bit xm_act    = 1'b0;
    bit xm_done   = 1'b0;

    uart_tx_feeder #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk           (clk),
        .rst           (rst),
        .wr_en         (wr_en),
        .wr_data       (wr_data),
        .full          (full),
        .empty         (empty),
        .count         (count),
        .overflow      (overflow),
        .tx_active     (tx_active),
        .tx_done       (tx_done),
        .data_valid    (data_valid),
        .transmit_byte (transmit_byte)
    );

    always #5 clk = ~clk;

    // Transmitter: takes a byte on data_valid, goes busy, then reports done for done_len cycles.
    initial begin : tx_model
        tx_active = 1'b0;
        tx_done   = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rst === 1'b1) begin
                xm_phase = 0;
                xm_act   = 1'b0;
                xm_done  = 1'b0;
            end else if (data_valid === 1'b1) begin
                n_dv++;
                n_cmp++;
                if (xm_phase != 0) begin
                    n_err++;
                    $display("FAIL one_outstanding: data_valid=1 with transmitter phase=%0d, required phase 0", xm_phase);
                end
                rx_q.push_back(transmit_byte);
                xm_phase = 1;
                xm_cnt   = act_dly;
            end else begin
                case (xm_phase)
                    1: if (xm_cnt == 0) begin xm_act = 1'b1; xm_phase = 2; xm_cnt = busy_len; end else xm_cnt--;
                    2: if (xm_cnt == 0) begin xm_act = 1'b0; xm_done = 1'b1; xm_phase = 3; xm_cnt = done_len - 1; end else xm_cnt--;
                    3: if (xm_cnt == 0) begin xm_done = 1'b0; xm_phase = 0; end else xm_cnt--;
                    default: ;
                endcase
            end
            tx_active = xm_act || hold_busy;
            tx_done   = xm_done || hold_done;
        end
    end

    // One clock of stimulus; the reference occupancy follows writes and observed pops.
    task automatic step(input logic we, input logic [7:0] d);
        bit popped;
        wr_en   = we;
        wr_data = d;
        @(posedge clk);
        #1;
        popped = (data_valid === 1'b1);
        m_ovf  = we && (m_cnt == int'(DEPTH)) && !popped;
        if (we && !m_ovf) begin
            exp_q.push_back(d);
            m_cnt++;
        end
        if (popped) m_cnt--;
        wr_en = 1'b0;
    endtask

    task automatic drain(input int budget, output bit ok);
        int k = 0;
        while (k < budget && !(rx_q.size() == exp_q.size() && xm_phase == 0 && m_cnt == 0)) begin
            step(1'b0, 8'h00);
            k++;
        end
        ok = (rx_q.size() == exp_q.size() && xm_phase == 0 && m_cnt == 0);
    endtask

    function automatic int first_diff();
        if (rx_q.size() != exp_q.size()) return -2;
        foreach (rx_q[i]) if (rx_q[i] != exp_q[i]) return i;
        return -1;
    endfunction

    task automatic clear_sb();
        exp_q.delete();
        rx_q.delete();
    endtask

    task automatic test_reset();
        #1;
        n_cmp++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags: count=%0d empty=%b full=%b, required 0/1/0", count, empty, full);
        end
        n_cmp++;
        if (overflow !== 1'b0 || data_valid !== 1'b0 || transmit_byte !== 8'h00) begin
            n_err++;
            $display("FAIL reset_outputs: overflow=%b data_valid=%b transmit_byte=%h, required 0/0/00", overflow, data_valid, transmit_byte);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        clear_sb();
    endtask

    task automatic test_single();
        bit ok;
        int dv0 = n_dv;
        act_dly = 1; busy_len = 2; done_len = 1;
        clear_sb();
        step(1'b1, 8'hA5);
        n_cmp++;
        if (data_valid !== 1'b0 || count !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL single_first_cycle: data_valid=%b count=%0d, required 0/1", data_valid, count);
        end
        step(1'b0, 8'h00);
        n_cmp++;
        if (data_valid !== 1'b1 || transmit_byte !== 8'hA5) begin
            n_err++;
            $display("FAIL single_latency: data_valid=%b transmit_byte=%h, required 1/a5", data_valid, transmit_byte);
        end
        step(1'b0, 8'h00);
        n_cmp++;
        if (data_valid !== 1'b0) begin
            n_err++;
            $display("FAIL single_pulse_width: data_valid=%b, required 0", data_valid);
        end
        drain(200, ok);
        n_cmp++;
        if (!ok) begin n_err++; $display("FAIL single_drain: sent=%0d, required %0d", rx_q.size(), exp_q.size()); end
        step(1'b0, 8'h00);
        n_cmp++;
        if (dut.r_state !== ST_IDLE || empty !== 1'b1 || transmit_byte !== 8'hA5) begin
            n_err++;
            $display("FAIL single_idle: state=%0d empty=%b byte=%h, required IDLE/1/a5", dut.r_state, empty, transmit_byte);
        end
        n_cmp++;
        if (n_dv - dv0 != 1 || first_diff() != -1) begin
            n_err++;
            $display("FAIL single_count: pulses=%0d diff=%0d, required 1/-1", n_dv - dv0, first_diff());
        end
    endtask

    task automatic test_burst();
        bit ok;
        act_dly = 0; busy_len = 1; done_len = 1;
        clear_sb();
        hold_busy = 1'b1;
        step(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) begin
            step(1'b1, 8'(i + 1));
            n_cmp++;
            if (count !== CNT_W'(m_cnt) || overflow !== 1'b0) begin
                n_err++;
                $display("FAIL burst_fill[%0d]: count=%0d overflow=%b, required %0d/0", i, count, overflow, m_cnt);
            end
        end
        n_cmp++;
        if (full !== 1'b1 || count !== CNT_W'(16)) begin
            n_err++;
            $display("FAIL burst_full: full=%b count=%0d, required 1/16", full, count);
        end
        step(1'b1, 8'h11);
        n_cmp++;
        if (overflow !== 1'b1 || count !== CNT_W'(16) || m_ovf !== 1'b1) begin
            n_err++;
            $display("FAIL burst_overflow: overflow=%b count=%0d, required 1/16", overflow, count);
        end
        step(1'b0, 8'h00);
        n_cmp++;
        if (overflow !== 1'b0) begin n_err++; $display("FAIL burst_ovf_pulse: overflow=%b, required 0", overflow); end
        hold_busy = 1'b0;
        drain(2000, ok);
        n_cmp++;
        if (!ok || first_diff() != -1 || rx_q.size() != 16) begin
            n_err++;
            $display("FAIL burst_order: diff=%0d sent=%0d, required -1/16", first_diff(), rx_q.size());
        end
        for (int i = 0; i < rx_q.size(); i++) begin
            n_cmp++;
            if (rx_q[i] !== 8'(i + 1)) begin
                n_err++;
                $display("FAIL burst_byte[%0d]: got=%h, required %h", i, rx_q[i], 8'(i + 1));
            end
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        act_dly = 0; busy_len = 1; done_len = 1;
        clear_sb();
        hold_busy = 1'b1;
        step(1'b0, 8'h00);
        for (int i = 0; i < 16; i++) step(1'b1, 8'($urandom));
        n_cmp++;
        if (count !== CNT_W'(16) || full !== 1'b1) begin
            n_err++;
            $display("FAIL simul_prefill: count=%0d full=%b, required 16/1", count, full);
        end
        hold_busy = 1'b0;
        step(1'b1, 8'h77);
        n_cmp++;
        if (data_valid !== 1'b1 || overflow !== 1'b0 || count !== CNT_W'(16)) begin
            n_err++;
            $display("FAIL simul_edge: data_valid=%b overflow=%b count=%0d, required 1/0/16", data_valid, overflow, count);
        end
        drain(2000, ok);
        n_cmp++;
        if (!ok || first_diff() != -1 || rx_q.size() != 17 || rx_q[rx_q.size() - 1] !== 8'h77) begin
            n_err++;
            $display("FAIL simul_order: diff=%0d sent=%0d, required -1/17 ending in 77", first_diff(), rx_q.size());
        end
    endtask

    task automatic test_done_hold();
        bit ok;
        int dv0 = n_dv;
        act_dly = $urandom_range(0, 2); busy_len = $urandom_range(0, 3); done_len = 2;
        clear_sb();
        hold_done = 1'b1;
        step(1'b0, 8'h00);
        step(1'b1, 8'($urandom));
        repeat (6) step(1'b0, 8'h00);
        n_cmp++;
        if (n_dv != dv0 || count !== CNT_W'(1)) begin
            n_err++;
            $display("FAIL stale_done: pulses=%0d count=%0d, required 0/1", n_dv - dv0, count);
        end
        hold_done = 1'b0;
        step(1'b1, 8'($urandom));
        step(1'b1, 8'($urandom));
        drain(500, ok);
        n_cmp++;
        if (!ok || n_dv - dv0 != 3 || first_diff() != -1) begin
            n_err++;
            $display("FAIL done_hold: pulses=%0d diff=%0d, required 3/-1", n_dv - dv0, first_diff());
        end
    endtask

    task automatic test_reset_mid();
        int k = 0;
        int dv0;
        act_dly = 0; busy_len = 40; done_len = 1;
        clear_sb();
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom_range(1, 255)));
        while (dut.r_state !== ST_WAIT_DONE && k < 10) begin step(1'b0, 8'h00); k++; end
        n_cmp++;
        if (dut.r_state !== ST_WAIT_DONE || count !== CNT_W'(5)) begin
            n_err++;
            $display("FAIL rstmid_setup: state=%0d count=%0d, required WAIT_DONE/5", dut.r_state, count);
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (count !== '0 || empty !== 1'b1 || full !== 1'b0 || overflow !== 1'b0 ||
            data_valid !== 1'b0 || transmit_byte !== 8'h00 || dut.r_state !== ST_IDLE) begin
            n_err++;
            $display("FAIL rstmid_async: count=%0d empty=%b full=%b ovf=%b dv=%b byte=%h, required 0/1/0/0/0/00",
                     count, empty, full, overflow, data_valid, transmit_byte);
        end
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_cnt = 0;
        clear_sb();
        dv0 = n_dv;
        for (int i = 0; i < 30; i++) begin
            step(1'b0, 8'h00);
            n_cmp++;
            if (data_valid !== 1'b0 || count !== '0) begin
                n_err++;
                $display("FAIL rstmid_quiet[%0d]: data_valid=%b count=%0d, required 0/0", i, data_valid, count);
            end
        end
        n_cmp++;
        if (n_dv != dv0) begin n_err++; $display("FAIL rstmid_pulses: pulses=%0d, required 0", n_dv - dv0); end
    endtask

    task automatic test_wrap();
        bit ok;
        bit we;
        int accepted = 0;
        int cyc = 0;
        clear_sb();
        while (accepted < 40 && cyc < 3000) begin
            if (cyc % 8 == 0) begin
                act_dly = $urandom_range(0, 1); busy_len = $urandom_range(0, 2); done_len = $urandom_range(1, 3);
            end
            we = ($urandom_range(0, 99) < 70);
            step(we, 8'($urandom));
            if (we && !m_ovf) accepted++;
            n_cmp++;
            if (count !== CNT_W'(m_cnt) || full !== (m_cnt == int'(DEPTH)) ||
                empty !== (m_cnt == 0) || overflow !== m_ovf) begin
                n_err++;
                $display("FAIL wrap_cycle[%0d]: count=%0d full=%b empty=%b ovf=%b, required %0d/%b/%b/%b",
                         cyc, count, full, empty, overflow, m_cnt, m_cnt == int'(DEPTH), m_cnt == 0, m_ovf);
            end
            cyc++;
        end
        drain(2000, ok);
        n_cmp++;
        if (!ok || first_diff() != -1 || rx_q.size() < 40) begin
            n_err++;
            $display("FAIL wrap_order: diff=%0d sent=%0d, required -1 and >=40", first_diff(), rx_q.size());
        end
    endtask

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        rst     = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        test_reset();
        test_single();
        test_burst();
        test_simultaneous();
        test_done_hold();
        test_reset_mid();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
